// File: rtl/mips_ctrl_pkg.sv
// Shared constants and state type for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

  // Instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control FSM states; encodings 12..15 are unreachable and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle. The control FSM is the master (it issues
// commands); the datapath/ALU/memory side is the slave.
// Handshake semantics: there is no valid/ready pair here. Every command
// signal is a level that is valid for the whole cycle in which it is driven
// and is consumed on the rising edge ending that cycle; opcode/funct/zero
// are levels from the IR and ALU that the master samples on the same edge.
interface multicycle_control_if #(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                zero;
  logic [3:0]          aluControlOut;
  logic                aluSrcA;
  logic [1:0]          aluSrcB;
  logic [1:0]          pcSrc;
  logic                pcEn;
  logic                iorD;
  logic                memWrite;
  logic                irWrite;
  logic                regDst;
  logic                memToReg;
  logic                regWrite;
  logic                instrDone;
  logic                illegalInstr;
  logic [CNT_W-1:0]    instrCount;

  modport master (
    input  opcode, funct, zero,
    output aluControlOut, aluSrcA, aluSrcB, pcSrc, pcEn, iorD, memWrite,
           irWrite, regDst, memToReg, regWrite, instrDone, illegalInstr,
           instrCount
  );

  modport slave (
    output opcode, funct, zero,
    input  aluControlOut, aluSrcA, aluSrcB, pcSrc, pcEn, iorD, memWrite,
           irWrite, regDst, memToReg, regWrite, instrDone, illegalInstr,
           instrCount
  );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct decoder: ALU control code plus a flag saying the funct is supported.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [FUNCT_W-1:0] funct,
  output logic [3:0]         alu_ctrl,
  output logic               funct_valid
);

  // Map funct to ALU operation; unsupported codes fall back to ADD, flagged invalid
  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with retired-instruction counter.
// Outputs are decoded from the current state; pcEn additionally uses zero.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus,
  output state_t                 state_dbg
);

  state_t           state;
  logic [CNT_W-1:0] count;

  logic [3:0] dec_alu;
  logic       dec_valid;
  logic       op_known;

  logic [3:0] alu_ctrl;
  logic       src_a;
  logic [1:0] src_b;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       branch;
  logic       ior_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       done;
  logic       illegal;

  alu_decoder #(.FUNCT_W(FUNCT_W)) u_alu_decoder (
    .funct       (bus.funct),
    .alu_ctrl    (dec_alu),
    .funct_valid (dec_valid)
  );

  // Opcode legality (R-type legality also needs a valid funct)
  always_comb begin
    op_known = 1'b0;
    case (bus.opcode)
      OP_RTYPE: op_known = dec_valid;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  // State sequencing and retired-instruction counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      count <= '0;
    end else begin
      if (done) count <= count + CNT_W'(1);
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_RTYPE:     state <= dec_valid ? S_EXECUTE : S_FETCH;
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state <= S_MEMWB;
        S_EXECUTE: state <= S_ALUWB;
        S_ADDIEX:  state <= S_ADDIWB;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; unreachable encodings leave every enable low
  always_comb begin
    alu_ctrl   = ALU_ADD;
    src_a      = 1'b0;
    src_b      = SRCB_REGB;
    pc_src     = PCSRC_ALU;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ior_d      = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        src_b    = SRCB_FOUR;
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        src_b   = SRCB_IMMSH;
        illegal = ~op_known;
      end
      S_MEMADR: begin
        src_a = 1'b1;
        src_b = SRCB_IMM;
      end
      S_MEMRD: ior_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        done       = 1'b1;
      end
      S_MEMWR: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      S_EXECUTE: begin
        src_a    = 1'b1;
        src_b    = SRCB_REGB;
        alu_ctrl = dec_alu;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BRANCH: begin
        src_a    = 1'b1;
        src_b    = SRCB_REGB;
        alu_ctrl = ALU_SUB;
        pc_src   = PCSRC_ALUOUT;
        branch   = 1'b1;
        done     = 1'b1;
      end
      S_ADDIEX: begin
        src_a = 1'b1;
        src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are held off for the whole time reset is asserted
  assign bus.aluControlOut = alu_ctrl;
  assign bus.aluSrcA       = src_a;
  assign bus.aluSrcB       = src_b;
  assign bus.pcSrc         = pc_src;
  assign bus.pcEn          = (pc_write | (branch & bus.zero)) & ~reset;
  assign bus.iorD          = ior_d;
  assign bus.memWrite      = mem_write & ~reset;
  assign bus.irWrite       = ir_write & ~reset;
  assign bus.regDst        = reg_dst;
  assign bus.memToReg      = mem_to_reg;
  assign bus.regWrite      = reg_write & ~reset;
  assign bus.instrDone     = done;
  assign bus.illegalInstr  = illegal;
  assign bus.instrCount    = count;
  assign state_dbg         = state;

endmodule
